// File: rtl/lif_neuron_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron.
package lif_neuron_pkg;

  typedef logic [15:0] potential_t;
  typedef logic [7:0]  weight_t;

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    FIRE      = 2'd1,
    REFRACT   = 2'd2
  } lif_state_e;

  localparam potential_t POT_MAX = 16'hFFFF;

endpackage

// File: rtl/lif_neuron_if.sv
// Neuron-side bus: synapse spikes and controls in, spike/potential/status out.
interface lif_neuron_if
  import lif_neuron_pkg::*;
#(
  parameter int NUM_INPUTS = 8
) ();

  logic                  en;
  logic [NUM_INPUTS-1:0] in_spikes;
  potential_t            threshold;
  weight_t               leak;
  logic                  clear_count;
  logic                  spike_out;
  potential_t            membrane_v;
  logic                  refractory;
  potential_t            spike_count;

  modport master (
    output en, in_spikes, threshold, leak, clear_count,
    input  spike_out, membrane_v, refractory, spike_count
  );

  modport slave (
    input  en, in_spikes, threshold, leak, clear_count,
    output spike_out, membrane_v, refractory, spike_count
  );

endinterface

// File: rtl/lif_neuron_spike_popcount.sv
// Combinational population count of the incoming weighted-spike bits.
module spike_popcount #(
  parameter int NUM_INPUTS = 8
) (
  input  logic [NUM_INPUTS-1:0]            i_bits,
  output logic [$clog2(NUM_INPUTS+1)-1:0]  o_count
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      o_count = o_count + CNT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating integration, periodic leak,
// one-cycle output spike, refractory hold and a saturating spike counter.
module lif_neuron
  import lif_neuron_pkg::*;
#(
  parameter int NUM_INPUTS    = 8,
  parameter int SPIKE_GAIN    = 4,
  parameter int LEAK_PERIOD   = 16,
  parameter int REFRAC_CYCLES = 4
) (
  input logic         clk,
  input logic         rst,
  lif_neuron_if.slave nrn
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int LK_W  = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RF_W  = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

  function automatic potential_t sat_add(potential_t a, logic [31:0] b);
    logic [32:0] s;
    s = {17'd0, a} + {1'b0, b};
    return (s > {17'd0, POT_MAX}) ? POT_MAX : s[15:0];
  endfunction

  function automatic potential_t floor_sub(potential_t a, weight_t b);
    return (a > {8'd0, b}) ? (a - {8'd0, b}) : '0;
  endfunction

  logic [CNT_W-1:0] w_pop;
  logic [31:0]      w_sum;
  potential_t       w_acc;
  potential_t       w_v_next;
  logic             w_tick;
  logic             w_fire;
  logic             w_spike_out;

  lif_state_e       r_state;
  potential_t       r_v;
  logic             r_spike;
  logic             r_refr;
  potential_t       r_count;
  logic [LK_W-1:0]  r_leak_cnt;
  logic [RF_W-1:0]  r_ref_cnt;

  spike_popcount #(.NUM_INPUTS(NUM_INPUTS)) u_popcount (
    .i_bits  (nrn.in_spikes),
    .o_count (w_pop)
  );

  assign w_sum       = 32'(w_pop) * 32'($unsigned(SPIKE_GAIN));
  assign w_acc       = sat_add(r_v, w_sum);
  assign w_tick      = (r_leak_cnt == LK_W'(LEAK_PERIOD - 1));
  assign w_v_next    = w_tick ? floor_sub(w_acc, nrn.leak) : w_acc;
  assign w_fire      = (w_v_next >= nrn.threshold);
  // A held FIRE state must not repeat its pulse while en is low.
  assign w_spike_out = r_spike & nrn.en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INTEGRATE;
      r_v        <= '0;
      r_spike    <= 1'b0;
      r_refr     <= 1'b0;
      r_count    <= '0;
      r_leak_cnt <= '0;
      r_ref_cnt  <= '0;
    end else begin
      if (nrn.clear_count) begin
        r_count <= w_spike_out ? 16'd1 : 16'd0;
      end else if (w_spike_out && (r_count != POT_MAX)) begin
        r_count <= r_count + 16'd1;
      end

      if (nrn.en) begin
        r_leak_cnt <= w_tick ? '0 : r_leak_cnt + 1'b1;
        case (r_state)
          INTEGRATE: begin
            if (w_fire) begin
              r_state <= FIRE;
              r_spike <= 1'b1;
              r_v     <= '0;
            end else begin
              r_v     <= w_v_next;
            end
          end
          FIRE: begin
            r_spike <= 1'b0;
            r_v     <= '0;
            if (REFRAC_CYCLES > 0) begin
              r_state   <= REFRACT;
              r_refr    <= 1'b1;
              r_ref_cnt <= RF_W'(REFRAC_CYCLES);
            end else begin
              r_state   <= INTEGRATE;
            end
          end
          REFRACT: begin
            r_v <= '0;
            if (r_ref_cnt <= RF_W'(1)) begin
              r_state <= INTEGRATE;
              r_refr  <= 1'b0;
            end else begin
              r_ref_cnt <= r_ref_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= INTEGRATE;
            r_spike <= 1'b0;
            r_refr  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign nrn.spike_out   = w_spike_out;
  assign nrn.membrane_v  = r_v;
  assign nrn.refractory  = r_refr;
  assign nrn.spike_count = r_count;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron with default parameters (8 inputs, gain 4,
// leak period 16, refractory 4).
module tb_lif_neuron;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lif_neuron_if #(.NUM_INPUTS(8)) bus ();

  lif_neuron #(
    .NUM_INPUTS    (8),
    .SPIKE_GAIN    (4),
    .LEAK_PERIOD   (16),
    .REFRAC_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .nrn (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.en          = 1'b0;
    bus.in_spikes   = '0;
    bus.threshold   = '0;
    bus.leak        = '0;
    bus.clear_count = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.in_spikes = 8'hFF; bus.threshold = 16'd5;
    bus.leak = 8'd0; bus.clear_count = 1'b0;
    #2;
    checks++;
    if ({bus.spike_out, bus.refractory, bus.membrane_v, bus.spike_count} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got spk=%0b ref=%0b v=%0d cnt=%0d, want all 0",
               bus.spike_out, bus.refractory, bus.membrane_v, bus.spike_count);
    end
    tick(); tick();
    checks++;
    if (bus.membrane_v !== 16'd0 || bus.spike_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got v=%0d spk=%0b, want 0 0", bus.membrane_v, bus.spike_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_integrate_fire();
    do_reset();
    bus.threshold = 16'd10; bus.in_spikes = 8'h01; bus.en = 1'b1;
    tick();
    checks++;
    if (bus.membrane_v !== 16'd4) begin
      errors++; $display("FAIL int_v1: got %0d want 4", bus.membrane_v);
    end
    tick();
    checks++;
    if (bus.membrane_v !== 16'd8 || bus.spike_out !== 1'b0) begin
      errors++; $display("FAIL int_v2: got v=%0d spk=%0b want 8 0", bus.membrane_v, bus.spike_out);
    end
    tick();
    checks++;
    if (bus.spike_out !== 1'b1 || bus.membrane_v !== 16'd0 || bus.refractory !== 1'b0) begin
      errors++;
      $display("FAIL int_fire: got spk=%0b v=%0d ref=%0b want 1 0 0",
               bus.spike_out, bus.membrane_v, bus.refractory);
    end
    tick();
    checks++;
    if (bus.spike_out !== 1'b0 || bus.refractory !== 1'b1 || bus.spike_count !== 16'd1) begin
      errors++;
      $display("FAIL int_refr_entry: got spk=%0b ref=%0b cnt=%0d want 0 1 1",
               bus.spike_out, bus.refractory, bus.spike_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.refractory !== 1'b1 || bus.membrane_v !== 16'd0) begin
        errors++;
        $display("FAIL int_refr_hold%0d: got ref=%0b v=%0d want 1 0", i, bus.refractory, bus.membrane_v);
      end
    end
    tick();
    checks++;
    if (bus.refractory !== 1'b0 || bus.membrane_v !== 16'd0) begin
      errors++; $display("FAIL int_refr_exit: got ref=%0b v=%0d want 0 0", bus.refractory, bus.membrane_v);
    end
    tick();
    checks++;
    if (bus.membrane_v !== 16'd4) begin
      errors++; $display("FAIL int_resume: got %0d want 4", bus.membrane_v);
    end
  endtask

  task automatic test_leak();
    logic [15:0] vexp;
    do_reset();
    bus.threshold = 16'hFFFF; bus.in_spikes = 8'h01; bus.leak = 8'd0; bus.en = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.membrane_v !== 16'd20) begin
      errors++; $display("FAIL leak_preload: got %0d want 20", bus.membrane_v);
    end
    bus.in_spikes = 8'h00; bus.leak = 8'd3;
    vexp = 16'd20;
    for (int k = 6; k <= 130; k++) begin
      tick();
      if (k % 16 == 0) vexp = (vexp > 16'd3) ? vexp - 16'd3 : 16'd0;
      checks++;
      if (bus.membrane_v !== vexp) begin
        errors++; $display("FAIL leak_edge%0d: got %0d want %0d", k, bus.membrane_v, vexp);
      end
    end
    checks++;
    if (bus.membrane_v !== 16'd0) begin
      errors++; $display("FAIL leak_floor: got %0d want 0", bus.membrane_v);
    end
  endtask

  task automatic test_saturation();
    int early;
    early = 0;
    do_reset();
    bus.threshold = 16'hFFFF; bus.in_spikes = 8'hFF; bus.leak = 8'd0; bus.en = 1'b1;
    repeat (2047) begin
      tick();
      if (bus.spike_out !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL sat_early_fire: got %0d spikes want 0", early);
    end
    checks++;
    if (bus.membrane_v !== 16'd65504) begin
      errors++; $display("FAIL sat_pre: got %0d want 65504", bus.membrane_v);
    end
    tick();
    checks++;
    if (bus.spike_out !== 1'b1 || bus.membrane_v !== 16'd0) begin
      errors++; $display("FAIL sat_fire: got spk=%0b v=%0d want 1 0", bus.spike_out, bus.membrane_v);
    end
  endtask

  task automatic test_refract_inputs();
    do_reset();
    bus.threshold = 16'd64; bus.in_spikes = 8'hFF; bus.en = 1'b1;
    tick();
    checks++;
    if (bus.membrane_v !== 16'd32) begin
      errors++; $display("FAIL rin_v1: got %0d want 32", bus.membrane_v);
    end
    tick();
    checks++;
    if (bus.spike_out !== 1'b1) begin
      errors++; $display("FAIL rin_fire: got %0b want 1", bus.spike_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.spike_out !== 1'b0 || bus.membrane_v !== 16'd0 || bus.refractory !== 1'b1) begin
        errors++;
        $display("FAIL rin_hold%0d: got spk=%0b v=%0d ref=%0b want 0 0 1",
                 i, bus.spike_out, bus.membrane_v, bus.refractory);
      end
    end
    tick();
    checks++;
    if (bus.refractory !== 1'b0 || bus.membrane_v !== 16'd0) begin
      errors++; $display("FAIL rin_exit: got ref=%0b v=%0d want 0 0", bus.refractory, bus.membrane_v);
    end
    tick();
    checks++;
    if (bus.membrane_v !== 16'd32) begin
      errors++; $display("FAIL rin_resume: got %0d want 32", bus.membrane_v);
    end
    tick();
    checks++;
    if (bus.spike_out !== 1'b1) begin
      errors++; $display("FAIL rin_refire: got %0b want 1", bus.spike_out);
    end
  endtask

  task automatic test_en_toggle();
    do_reset();
    bus.threshold = 16'd10; bus.in_spikes = 8'h01; bus.en = 1'b1;
    tick(); tick();
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.membrane_v !== 16'd8 || bus.spike_out !== 1'b0) begin
        errors++;
        $display("FAIL en_hold%0d: got v=%0d spk=%0b want 8 0", i, bus.membrane_v, bus.spike_out);
      end
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.spike_out !== 1'b1) begin
      errors++; $display("FAIL en_deferred_fire: got %0b want 1", bus.spike_out);
    end
    bus.en = 1'b0;
    #1;
    checks++;
    if (bus.spike_out !== 1'b0) begin
      errors++; $display("FAIL en_force0: got %0b want 0", bus.spike_out);
    end
    tick();
    checks++;
    if (bus.spike_out !== 1'b0 || bus.refractory !== 1'b0 || bus.spike_count !== 16'd0) begin
      errors++;
      $display("FAIL en_fire_hold: got spk=%0b ref=%0b cnt=%0d want 0 0 0",
               bus.spike_out, bus.refractory, bus.spike_count);
    end
    bus.en = 1'b1;
    #1;
    checks++;
    if (bus.spike_out !== 1'b1) begin
      errors++; $display("FAIL en_fire_resume: got %0b want 1", bus.spike_out);
    end
    tick();
    checks++;
    if (bus.refractory !== 1'b1 || bus.spike_count !== 16'd1) begin
      errors++; $display("FAIL en_count: got ref=%0b cnt=%0d want 1 1", bus.refractory, bus.spike_count);
    end
  endtask

  task automatic test_reset_mid_refract();
    do_reset();
    bus.threshold = 16'd0; bus.in_spikes = 8'h00; bus.en = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      tick();
      if (k == 1 || k == 7) begin
        checks++;
        if (bus.spike_out !== 1'b1) begin
          errors++; $display("FAIL thr0_fire_e%0d: got %0b want 1", k, bus.spike_out);
        end
      end
      if (k == 2) begin
        checks++;
        if (bus.refractory !== 1'b1) begin
          errors++; $display("FAIL thr0_refr: got %0b want 1", bus.refractory);
        end
      end
    end
    checks++;
    if (bus.spike_count !== 16'd7 || bus.refractory !== 1'b1) begin
      errors++;
      $display("FAIL rstm_pre: got cnt=%0d ref=%0b want 7 1", bus.spike_count, bus.refractory);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.spike_out, bus.refractory, bus.membrane_v, bus.spike_count} !== 34'd0) begin
      errors++;
      $display("FAIL rstm_async: got spk=%0b ref=%0b v=%0d cnt=%0d want all 0",
               bus.spike_out, bus.refractory, bus.membrane_v, bus.spike_count);
    end
    bus.en = 1'b0; bus.threshold = 16'd10; bus.in_spikes = 8'h01;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.spike_count !== 16'd0) begin
      errors++; $display("FAIL rstm_count: got %0d want 0", bus.spike_count);
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.membrane_v !== 16'd4 || bus.refractory !== 1'b0 || bus.spike_count !== 16'd0) begin
      errors++;
      $display("FAIL rstm_integrate: got v=%0d ref=%0b cnt=%0d want 4 0 0",
               bus.membrane_v, bus.refractory, bus.spike_count);
    end
  endtask

  task automatic test_clear_count();
    do_reset();
    bus.threshold = 16'd0; bus.in_spikes = 8'h00; bus.en = 1'b1;
    repeat (7) tick();
    checks++;
    if (bus.spike_out !== 1'b1 || bus.spike_count !== 16'd1) begin
      errors++;
      $display("FAIL clr_pre: got spk=%0b cnt=%0d want 1 1", bus.spike_out, bus.spike_count);
    end
    bus.clear_count = 1'b1;
    tick();
    checks++;
    if (bus.spike_count !== 16'd1) begin
      errors++; $display("FAIL clr_with_spike: got %0d want 1", bus.spike_count);
    end
    tick();
    checks++;
    if (bus.spike_count !== 16'd0) begin
      errors++; $display("FAIL clr_plain: got %0d want 0", bus.spike_count);
    end
    bus.clear_count = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en = 1'b0; bus.in_spikes = '0; bus.threshold = '0;
    bus.leak = '0; bus.clear_count = 1'b0;
    test_reset();
    test_integrate_fire();
    test_leak();
    test_saturation();
    test_refract_inputs();
    test_en_toggle();
    test_reset_mid_refract();
    test_clear_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
